// File: rtl/tx_fc_credit_gate_if.sv
// Handshake bundle between the Tx arbiter/DLL side (master) and the flow-control credit gate (slave).
// Carries the credit updates, the per-cycle request set and the registered grant result.
interface tx_fc_credit_gate_if #(
  parameter int unsigned FC_HDR_WIDTH  = 12,
  parameter int unsigned FC_DATA_WIDTH = 16,
  parameter int unsigned NUM_FC_TYPES  = 3,
  parameter int unsigned NUM_REQ       = 2
);
  localparam int unsigned TYPE_W = (NUM_FC_TYPES > 1) ? $clog2(NUM_FC_TYPES) : 1;
  localparam int unsigned RES_W  = $clog2(NUM_REQ + 1);

  logic                        fc_upd_valid;
  logic [TYPE_W-1:0]           fc_upd_type;
  logic [FC_HDR_WIDTH-1:0]     fc_upd_hdr;
  logic [FC_DATA_WIDTH-1:0]    fc_upd_data;
  logic [2*NUM_REQ-1:0]        req_cmd;
  logic [TYPE_W*NUM_REQ-1:0]   req_type;
  logic [10*NUM_REQ-1:0]       req_len;
  logic [NUM_REQ-1:0]          req_has_data;
  logic                        res_valid;
  logic [RES_W-1:0]            res_grant_cnt;

  modport master (
    output fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    output req_cmd, req_type, req_len, req_has_data,
    input  res_valid, res_grant_cnt
  );

  modport slave (
    input  fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data,
    input  req_cmd, req_type, req_len, req_has_data,
    output res_valid, res_grant_cnt
  );
endinterface

// File: rtl/tx_fc_credit_gate.sv
// Transmit flow-control credit tracker and in-order gate with modulo credit arithmetic.
// Optional per-type stall counters are enabled by defining TX_FC_STALL_CNT_EN.
module tx_fc_credit_gate #(
  parameter int unsigned FC_HDR_WIDTH  = 12,
  parameter int unsigned FC_DATA_WIDTH = 16,
  parameter int unsigned NUM_FC_TYPES  = 3,
  parameter int unsigned NUM_REQ       = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TX_FC_STALL_CNT_EN
  input  logic                       stall_clr,
  output logic [16*NUM_FC_TYPES-1:0] stall_cnt,
`endif
  tx_fc_credit_gate_if.slave bus
);
  localparam int unsigned NT     = NUM_FC_TYPES;
  localparam int unsigned TYPE_W = (NUM_FC_TYPES > 1) ? $clog2(NUM_FC_TYPES) : 1;
  localparam int unsigned RES_W  = $clog2(NUM_REQ + 1);
  localparam logic [FC_HDR_WIDTH-1:0]  HdrHalf  = {1'b1, {(FC_HDR_WIDTH-1){1'b0}}};
  localparam logic [FC_DATA_WIDTH-1:0] DataHalf = {1'b1, {(FC_DATA_WIDTH-1){1'b0}}};
  localparam logic [1:0] CmdCheck   = 2'b01;
  localparam logic [1:0] CmdConsume = 2'b10;

  logic [FC_HDR_WIDTH-1:0]  hdr_cl_q [NT], hdr_cl_d [NT], hdr_cc_q [NT], hdr_cc_d [NT];
  logic [FC_DATA_WIDTH-1:0] data_cl_q [NT], data_cl_d [NT], data_cc_q [NT], data_cc_d [NT];
  logic [NT-1:0]            lim_vld_q, lim_vld_d, hdr_inf_q, hdr_inf_d, data_inf_q, data_inf_d;
  logic                     res_valid_q, res_valid_d;
  logic [RES_W-1:0]         grant_cnt_q, grant_cnt_d;

  logic [FC_HDR_WIDTH-1:0]  hdr_run [NT];
  logic [FC_DATA_WIDTH-1:0] data_run [NT];
  logic [FC_HDR_WIDTH-1:0]  hdr_need;
  logic [FC_DATA_WIDTH-1:0] data_need, data_req_w;
  logic [1:0]               cmd;
  logic [TYPE_W-1:0]        typ, tidx, uidx;
  logic [9:0]               len;
  logic [8:0]               data_req;
  logic                     is_op, type_ok, upd_ok, hdr_ok, data_ok, pass, eval_go;

  always_comb begin
    hdr_cl_d    = hdr_cl_q;
    hdr_cc_d    = hdr_cc_q;
    data_cl_d   = data_cl_q;
    data_cc_d   = data_cc_q;
    lim_vld_d   = lim_vld_q;
    hdr_inf_d   = hdr_inf_q;
    data_inf_d  = data_inf_q;
    hdr_run     = hdr_cc_q;
    data_run    = data_cc_q;
    grant_cnt_d = '0;
    res_valid_d = 1'b0;
    eval_go     = 1'b1;
    cmd = '0; typ = '0; tidx = '0; len = '0; data_req = '0; data_req_w = '0;
    hdr_need = '0; data_need = '0; is_op = 1'b0; type_ok = 1'b0;
    hdr_ok = 1'b0; data_ok = 1'b0; pass = 1'b0;

    // Running CC copies let later requests see credits of earlier grants in this cycle.
    for (int k = 0; k < NUM_REQ; k++) begin
      cmd     = bus.req_cmd[2*k +: 2];
      typ     = bus.req_type[TYPE_W*k +: TYPE_W];
      len     = bus.req_len[10*k +: 10];
      is_op   = (cmd == CmdCheck) || (cmd == CmdConsume);
      type_ok = 32'(typ) < NT;
      tidx    = type_ok ? typ : '0;
      if (!bus.req_has_data[k])  data_req = '0;
      else if (len == 10'd0)     data_req = 9'd256;
      else                       data_req = {1'b0, len[9:2]} + 9'(len[1:0] != 2'b00);
      data_req_w = FC_DATA_WIDTH'(data_req);
      hdr_need   = hdr_run[tidx] + FC_HDR_WIDTH'(1);
      data_need  = data_run[tidx] + data_req_w;
      hdr_ok     = hdr_inf_q[tidx] || ((hdr_cl_q[tidx] - hdr_need) <= HdrHalf);
      data_ok    = data_inf_q[tidx] || ((data_cl_q[tidx] - data_need) <= DataHalf);
      pass       = is_op && type_ok && lim_vld_q[tidx] && hdr_ok && data_ok;
      res_valid_d = res_valid_d | is_op;
      if (eval_go && pass) begin
        grant_cnt_d     = grant_cnt_d + RES_W'(1);
        hdr_run[tidx]   = hdr_need;
        data_run[tidx]  = data_need;
        if (cmd == CmdConsume) begin
          if (!hdr_inf_q[tidx])  hdr_cc_d[tidx]  = hdr_cc_d[tidx] + FC_HDR_WIDTH'(1);
          if (!data_inf_q[tidx]) data_cc_d[tidx] = data_cc_d[tidx] + data_req_w;
        end
      end else begin
        eval_go = 1'b0;
      end
    end

    // Zero on the first update means infinite; an infinite field ignores all later updates.
    upd_ok = bus.fc_upd_valid && (32'(bus.fc_upd_type) < NT);
    uidx   = upd_ok ? bus.fc_upd_type : '0;
    if (upd_ok) begin
      lim_vld_d[uidx] = 1'b1;
      if (!hdr_inf_q[uidx]) begin
        hdr_cl_d[uidx] = bus.fc_upd_hdr;
        if (!lim_vld_q[uidx] && bus.fc_upd_hdr == '0) hdr_inf_d[uidx] = 1'b1;
      end
      if (!data_inf_q[uidx]) begin
        data_cl_d[uidx] = bus.fc_upd_data;
        if (!lim_vld_q[uidx] && bus.fc_upd_data == '0) data_inf_d[uidx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) begin
        hdr_cl_q[t]  <= '0;
        hdr_cc_q[t]  <= '0;
        data_cl_q[t] <= '0;
        data_cc_q[t] <= '0;
      end
      lim_vld_q   <= '0;
      hdr_inf_q   <= '0;
      data_inf_q  <= '0;
      res_valid_q <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      hdr_cl_q    <= hdr_cl_d;
      hdr_cc_q    <= hdr_cc_d;
      data_cl_q   <= data_cl_d;
      data_cc_q   <= data_cc_d;
      lim_vld_q   <= lim_vld_d;
      hdr_inf_q   <= hdr_inf_d;
      data_inf_q  <= data_inf_d;
      res_valid_q <= res_valid_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.res_valid     = res_valid_q;
  assign bus.res_grant_cnt = grant_cnt_q;

`ifdef TX_FC_STALL_CNT_EN
  logic [15:0]       stall_q [NT], stall_d [NT];
  logic [1:0]        s_cmd;
  logic [TYPE_W-1:0] s_typ;
  logic              s_found;

  // The first non-NOP request beyond the granted prefix is charged to its type.
  always_comb begin
    stall_d = stall_q;
    s_found = 1'b0;
    s_cmd   = '0;
    s_typ   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_cmd = bus.req_cmd[2*k +: 2];
      s_typ = bus.req_type[TYPE_W*k +: TYPE_W];
      if (!s_found && (k >= 32'(grant_cnt_d)) &&
          ((s_cmd == CmdCheck) || (s_cmd == CmdConsume))) begin
        s_found = 1'b1;
        if ((32'(s_typ) < NT) && (stall_d[s_typ] != 16'hFFFF)) begin
          stall_d[s_typ] = stall_d[s_typ] + 16'd1;
        end
      end
    end
    if (stall_clr) begin
      for (int t = 0; t < NT; t++) stall_d[t] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) stall_q[t] <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  always_comb begin
    for (int t = 0; t < NT; t++) stall_cnt[16*t +: 16] = stall_q[t];
  end
`endif
endmodule
